// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes,
// data-memory wait freezes and a drain-then-halt sequence.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ifid_valid,
    input  logic [1:0] ifid_rs,
    input  logic [1:0] ifid_rt,
    input  logic       ifid_uses_rs,
    input  logic       ifid_uses_rt,
    input  logic       idex_mem_read,
    input  logic [1:0] idex_rd,
    input  logic       branch_taken,
    input  logic       mem_busy,
    input  logic       halt_req,
    input  logic       resume,
    input  logic       stall_cnt_clr,
    output logic       pc_en,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       pipe_freeze,
    output logic       halted,
    output logic [7:0] stall_cnt
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] DRAIN_ONE  = CW'(1);

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        DRAIN,
        HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] drain_cnt;
    logic [CW-1:0] drain_nxt;

    logic rs_hit;
    logic rt_hit;
    logic load_use;

    logic   r_pc_en;
    logic   r_stall;
    logic   r_freeze;
    logic   r_ifid_flush;
    logic   r_idex_flush;
    logic   r_load_drain;
    state_t r_next;

    assign rs_hit   = ifid_uses_rs && (ifid_rs == idex_rd);
    assign rt_hit   = ifid_uses_rt && (ifid_rt == idex_rd);
    assign load_use = ifid_valid && idex_mem_read && (rs_hit || rt_hit);

    // Priority rules shared by RUN and by MEMWAIT once memory is ready
    always_comb begin
        r_pc_en      = 1'b1;
        r_stall      = 1'b0;
        r_freeze     = 1'b0;
        r_ifid_flush = 1'b0;
        r_idex_flush = 1'b0;
        r_load_drain = 1'b0;
        r_next       = RUN;
        if (mem_busy) begin
            r_pc_en  = 1'b0;
            r_stall  = 1'b1;
            r_freeze = 1'b1;
            r_next   = MEMWAIT;
        end else if (branch_taken) begin
            r_ifid_flush = 1'b1;
            r_idex_flush = 1'b1;
        end else if (load_use) begin
            r_pc_en      = 1'b0;
            r_stall      = 1'b1;
            r_idex_flush = 1'b1;
        end else if (halt_req) begin
            r_pc_en      = 1'b0;
            r_ifid_flush = 1'b1;
            r_load_drain = 1'b1;
            r_next       = DRAIN;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        unique case (state)
            RUN, MEMWAIT: begin
                pc_en       = r_pc_en;
                ifid_stall  = r_stall;
                ifid_flush  = r_ifid_flush;
                idex_flush  = r_idex_flush;
                pipe_freeze = r_freeze;
                state_nxt   = r_next;
                if (r_load_drain) begin
                    drain_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    pipe_freeze = 1'b1;
                    ifid_stall  = 1'b1;
                end else begin
                    // A late branch still lets the PC capture its target
                    pc_en      = branch_taken;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (drain_cnt <= DRAIN_ONE) begin
                        drain_nxt = '0;
                        state_nxt = HALT;
                    end else begin
                        drain_nxt = drain_cnt - DRAIN_ONE;
                    end
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                halted     = 1'b1;
                if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                drain_nxt = '0;
            end
        endcase
        if (reset) begin
            pc_en       = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pipe_freeze = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall_cnt_clr) begin
            stall_cnt <= 8'd0;
        end else if (!pc_en && state != HALT && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ifid_valid;
    logic [1:0] ifid_rs;
    logic [1:0] ifid_rt;
    logic       ifid_uses_rs;
    logic       ifid_uses_rt;
    logic       idex_mem_read;
    logic [1:0] idex_rd;
    logic       branch_taken;
    logic       mem_busy;
    logic       halt_req;
    logic       resume;
    logic       stall_cnt_clr;
    logic       pc_en;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       pipe_freeze;
    logic       halted;
    logic [7:0] stall_cnt;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk),
        .reset(reset),
        .ifid_valid(ifid_valid),
        .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt),
        .ifid_uses_rs(ifid_uses_rs),
        .ifid_uses_rt(ifid_uses_rt),
        .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd),
        .branch_taken(branch_taken),
        .mem_busy(mem_busy),
        .halt_req(halt_req),
        .resume(resume),
        .stall_cnt_clr(stall_cnt_clr),
        .pc_en(pc_en),
        .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze),
        .halted(halted),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // ctl = {pc_en, ifid_stall, ifid_flush, idex_flush, pipe_freeze, halted}
    localparam logic [5:0] NORM   = 6'b100000;
    localparam logic [5:0] LDUSE  = 6'b010100;
    localparam logic [5:0] BRFL   = 6'b101100;
    localparam logic [5:0] FRZ    = 6'b010010;
    localparam logic [5:0] HENTRY = 6'b001000;
    localparam logic [5:0] DRN    = 6'b001100;
    localparam logic [5:0] HLT    = 6'b001101;
    localparam logic [5:0] RST    = 6'b001100;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [13:0] got;
            e   = sb.pop_front();
            got = {pc_en, ifid_stall, ifid_flush, idex_flush,
                   pipe_freeze, halted, stall_cnt};
            n_cmp++;
            if (got !== {e.ctl, e.cnt}) begin
                n_bad++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         e.name, got[13:8], got[7:0], e.ctl, e.cnt);
            end
        end
    end

    task automatic idle();
        ifid_valid    = 1'b0;
        ifid_rs       = 2'd0;
        ifid_rt       = 2'd0;
        ifid_uses_rs  = 1'b0;
        ifid_uses_rt  = 1'b0;
        idex_mem_read = 1'b0;
        idex_rd       = 2'd0;
        branch_taken  = 1'b0;
        mem_busy      = 1'b0;
        halt_req      = 1'b0;
        resume        = 1'b0;
        stall_cnt_clr = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [5:0] ctl,
                       input logic [7:0] cnt);
        exp_t x;
        x.name = nm;
        x.ctl  = ctl;
        x.cnt  = cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic ld_rs();
        idle();
        ifid_valid    = 1'b1;
        idex_mem_read = 1'b1;
        idex_rd       = 2'd2;
        ifid_rs       = 2'd2;
        ifid_uses_rs  = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc("reset_state", RST, 8'd0);
        reset = 1'b0;

        idle();          cyc("normal", NORM, 8'd0);
        ld_rs();         cyc("loaduse_rs", LDUSE, 8'd0);
        idle();          cyc("after_ld", NORM, 8'd1);
        idle();
        ifid_valid = 1'b1; idex_mem_read = 1'b1; idex_rd = 2'd3;
        ifid_rt = 2'd3; ifid_uses_rt = 1'b1; ifid_rs = 2'd3;
        cyc("loaduse_rt", LDUSE, 8'd1);
        ld_rs(); ifid_uses_rs = 1'b0; ifid_rt = 2'd2;
        cyc("no_use_flag", NORM, 8'd2);
        ld_rs(); ifid_valid = 1'b0;
        cyc("ifid_invalid", NORM, 8'd2);
        ld_rs(); branch_taken = 1'b1;
        cyc("br_over_ld", BRFL, 8'd2);
        idle();          cyc("after_br", NORM, 8'd2);

        idle(); mem_busy = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) cyc("memwait", FRZ, 8'(2 + i));
        mem_busy = 1'b0;
        cyc("memwait_br", BRFL, 8'd6);
        idle();          cyc("after_mw", NORM, 8'd6);

        halt_req = 1'b1; cyc("halt_entry", HENTRY, 8'd6);
        idle();
        for (int i = 0; i < 3; i++) cyc("drain", DRN, 8'(7 + i));
        halt_req = 1'b1; cyc("halt_ign", HLT, 8'd10);
        idle();          cyc("halt_hold", HLT, 8'd10);
        resume = 1'b1;   cyc("halt_resume", HLT, 8'd10);
        idle();          cyc("post_resume", NORM, 8'd10);

        halt_req = 1'b1; cyc("halt_entry2", HENTRY, 8'd10);
        idle(); mem_busy = 1'b1;
        cyc("drain_busy", FRZ, 8'd11);
        idle(); branch_taken = 1'b1;
        cyc("drain_br", BRFL, 8'd12);
        idle();          cyc("drain2a", DRN, 8'd12);
        idle();          cyc("drain2b", DRN, 8'd13);
        idle();          cyc("halt2", HLT, 8'd14);
        resume = 1'b1;   cyc("resume2", HLT, 8'd14);
        idle(); stall_cnt_clr = 1'b1;
        cyc("clr_req", NORM, 8'd14);
        idle();          cyc("clr_done", NORM, 8'd0);

        idle(); mem_busy = 1'b1;
        for (int i = 0; i < 300; i++)
            cyc("sat_run", FRZ, (i > 255) ? 8'd255 : 8'(i));
        idle();          cyc("sat_hold", NORM, 8'd255);
        mem_busy = 1'b1; stall_cnt_clr = 1'b1;
        cyc("clr_vs_inc", FRZ, 8'd255);
        idle();          cyc("sat_cleared", NORM, 8'd0);

        halt_req = 1'b1; cyc("halt_entry3", HENTRY, 8'd0);
        idle();          cyc("drain3", DRN, 8'd1);
        reset = 1'b1; mem_busy = 1'b1; branch_taken = 1'b1;
        cyc("reset_in_drain", RST, 8'd2);
        reset = 1'b0;
        idle();          cyc("post_reset", NORM, 8'd0);
        idle();          cyc("post_reset2", NORM, 8'd0);

        @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
